// File: rtl/hptdc_parallel_readout_pkg.sv
// Shared types, default widths and round-robin helpers for the multi-chip HPTDC reader.
package hptdc_readout_pkg;

  typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_N_CHIPS   = 4;
  localparam int DEF_BUF_DEPTH = 8;
  localparam int DEF_ID_W      = 4;
  localparam int MAX_CHIPS     = 16;

  // First requester at or after ptr (modulo n); -1 when nobody requests.
  function automatic int rr_pick(input logic [MAX_CHIPS-1:0] req, input int ptr, input int n);
    int idx;
    logic [MAX_CHIPS-1:0] sh;
    rr_pick = -1;
    for (int k = MAX_CHIPS-1; k >= 0; k--) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      sh = req >> idx;
      if (k < n && sh[0]) rr_pick = idx;
    end
  endfunction

  function automatic int rr_next(input int sel, input int n);
    return (sel >= n-1) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/hptdc_parallel_readout_if.sv
// Downstream event-FIFO write port: word, valid and back-pressure.
interface hptdc_parallel_readout_if #(parameter int OUT_W = 32);
  logic [OUT_W-1:0] data_out;
  logic             data_ready;
  logic             full;

  modport master (output data_out, data_ready, input full);
  modport slave  (input data_out, data_ready, output full);
endinterface

// File: rtl/hptdc_parallel_readout_word_fifo.sv
// Synchronous first-word-fall-through buffer; head word is visible whenever non-empty.
module hptdc_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/hptdc_parallel_readout.sv
// Round-robin reader for N_CHIPS HPTDC parallel ports feeding a downstream event FIFO.
// Optional TAG_CHIP_ID_EN prepends the chip index to every buffered word.
module hptdc_parallel_readout
  import hptdc_readout_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int N_CHIPS   = DEF_N_CHIPS,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int ID_W      = DEF_ID_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CHIPS*DATA_W-1:0]    hptdc_data,
  input  logic [N_CHIPS-1:0]           hptdc_data_ready,
  output logic [N_CHIPS-1:0]           hptdc_get_data,
  input  logic [N_CHIPS-1:0]           hptdc_error,
  output logic [N_CHIPS-1:0]           error_flags,
  output logic [$clog2(BUF_DEPTH):0]   buf_level,
  hptdc_parallel_readout_if.master     dn
);
`ifdef TAG_CHIP_ID_EN
  localparam int OUT_W = DATA_W + ID_W;
`else
  localparam int OUT_W = DATA_W;
`endif

  state_t               state;
  logic [ID_W-1:0]      ptr, sel;
  logic                 cap_vld;
  logic [OUT_W-1:0]     cap_word;
  logic [MAX_CHIPS-1:0] req;
  logic                 sel_rdy;
  logic [DATA_W-1:0]    sel_word;
  logic                 pop, slot_free, fifo_empty, fifo_full;
  int                   pick;

  assign req = MAX_CHIPS'(hptdc_data_ready);
  assign pop = dn.data_ready & ~dn.full;
  // A pop in the deciding cycle frees a slot before the new word lands.
  assign slot_free = ~fifo_full | pop;

  always_comb pick = rr_pick(req, int'(ptr), N_CHIPS);

  always_comb begin
    sel_rdy  = 1'b0;
    sel_word = '0;
    for (int i = 0; i < N_CHIPS; i++)
      if (sel == ID_W'(i)) begin
        sel_rdy  = hptdc_data_ready[i];
        sel_word = hptdc_data[i*DATA_W +: DATA_W];
      end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      sel            <= '0;
      hptdc_get_data <= '0;
      cap_vld        <= 1'b0;
      cap_word       <= '0;
      error_flags    <= '0;
    end else begin
      error_flags <= error_flags | hptdc_error;
      cap_vld     <= 1'b0;
      case (state)
        IDLE:
          if (pick >= 0 && slot_free) begin
            sel            <= ID_W'(pick);
            hptdc_get_data <= N_CHIPS'(1) << pick;
            state          <= STROBE;
          end
        STROBE: begin
          hptdc_get_data <= '0;
          // A chip that withdrew ready during the strobe yields no word.
          cap_vld <= sel_rdy;
`ifdef TAG_CHIP_ID_EN
          cap_word <= {sel, sel_word};
`else
          cap_word <= sel_word;
`endif
          ptr   <= ID_W'(rr_next(int'(sel), N_CHIPS));
          state <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  hptdc_word_fifo #(.WIDTH(OUT_W), .DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (cap_vld),
    .din   (cap_word),
    .pop   (pop),
    .dout  (dn.data_out),
    .level (buf_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign dn.data_ready = ~fifo_empty;
endmodule

// File: tb/tb_hptdc_parallel_readout.sv
// Bench for hptdc_parallel_readout: queue-based chip/buffer model plus directed literal checks.
module tb_hptdc_parallel_readout;
  localparam int DATA_W = 32, N = 4, D = 8, ID_W = 4;
`ifdef TAG_CHIP_ID_EN
  localparam int OUT_W = DATA_W + ID_W;
`else
  localparam int OUT_W = DATA_W;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic [N*DATA_W-1:0] hptdc_data = '0;
  logic [N-1:0] hptdc_data_ready = '0, hptdc_error = '0;
  logic [N-1:0] hptdc_get_data, error_flags;
  logic [$clog2(D):0] buf_level;

  hptdc_parallel_readout_if #(.OUT_W(OUT_W)) dn ();

  hptdc_parallel_readout #(.DATA_W(DATA_W), .N_CHIPS(N), .BUF_DEPTH(D), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .hptdc_data(hptdc_data), .hptdc_data_ready(hptdc_data_ready),
    .hptdc_get_data(hptdc_get_data), .hptdc_error(hptdc_error), .error_flags(error_flags),
    .buf_level(buf_level), .dn(dn));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit checking = 0;
  logic [DATA_W-1:0] chip_q [N][$];
  logic [N-1:0] rdy_mask = '1, gd_took = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] tagw(input int c, input logic [DATA_W-1:0] w);
`ifdef TAG_CHIP_ID_EN
    return {ID_W'(c), w};
`else
    return OUT_W'(w + 0*c);
`endif
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Chip models: each chip presents the head of its queue, consumed when strobed while ready.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (gd_took[i] && chip_q[i].size() > 0) void'(chip_q[i].pop_front());
      hptdc_data_ready[i] = (chip_q[i].size() > 0) && rdy_mask[i];
      hptdc_data[i*DATA_W +: DATA_W] = (chip_q[i].size() > 0) ? chip_q[i][0] : '0;
    end
  end

  // Reference: strobe schedule from the round-robin rule, buffer as a queue of visible words.
  logic [N-1:0] exp_get = '0, err_m = '0;
  int since = 99, m_ptr = 0;
  logic st_v = 1'b0;
  logic [OUT_W-1:0] st_w = '0;
  logic [OUT_W-1:0] mq [$];

  always @(negedge clk) begin : model
    int lvl, s, c;
    bit popm;
    logic [N-1:0] nxt;
    if (checking) begin
      chk("get_data", 64'(hptdc_get_data), 64'(exp_get));
      chk("data_ready", 64'(dn.data_ready), 64'(mq.size() > 0));
      if (mq.size() > 0) chk("data_out", 64'(dn.data_out), 64'(mq[0]));
      chk("buf_level", 64'(buf_level), 64'(mq.size()));
      chk("error_flags", 64'(error_flags), 64'(err_m));
    end
    gd_took = hptdc_get_data & hptdc_data_ready;
    if (reset) begin
      mq.delete();
      exp_get = '0; since = 99; m_ptr = 0; st_v = 1'b0; err_m = '0;
    end else begin
      lvl  = mq.size();
      popm = (lvl > 0) && !dn.full;
      nxt  = '0;
      if (since >= 2 && (lvl < D || popm))
        for (int k = N-1; k >= 0; k--) begin
          c = (m_ptr + k) % N;
          if (hptdc_data_ready[c]) nxt = N'(1) << c;
        end
      if (popm) void'(mq.pop_front());
      if (st_v) mq.push_back(st_w);
      st_v = 1'b0;
      if (exp_get != '0) begin
        s     = oh2i(exp_get);
        st_v  = hptdc_data_ready[s];
        st_w  = tagw(s, hptdc_data[s*DATA_W +: DATA_W]);
        m_ptr = (s + 1) % N;
      end
      err_m = err_m | hptdc_error;
      since = (nxt != '0) ? 0 : (since < 99 ? since + 1 : since);
      exp_get = nxt;
    end
  end

  task automatic at_edge();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    at_edge(); reset = 1'b1;
    at_edge(); reset = 1'b0;
    @(negedge clk);
    chk("rst_get_data", 64'(hptdc_get_data), 64'd0);
    chk("rst_data_ready", 64'(dn.data_ready), 64'd0);
    chk("rst_data_out", 64'(dn.data_out), 64'd0);
    chk("rst_buf_level", 64'(buf_level), 64'd0);
    chk("rst_error_flags", 64'(error_flags), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    bit busy = 1;
    while (busy && n < 400) begin
      @(negedge clk); n++;
      busy = dn.data_ready || (hptdc_get_data != '0);
      for (int i = 0; i < N; i++) if (chip_q[i].size() > 0) busy = 1;
    end
    chk("drain_timeout", 64'(n < 400), 64'd1);
  endtask

  function automatic logic [DATA_W-1:0] t3w(input int c, input int k);
    return 32'hC000_0000 | DATA_W'(c << 8) | DATA_W'(k);
  endfunction

  initial begin : main
    int n, cnt;
    int got [8];
    int at [8];
    dn.full = 1'b0;
    at_edge(); at_edge(); reset = 1'b0; checking = 1;
    @(negedge clk);
    chk("init_get_data", 64'(hptdc_get_data), 64'd0);
    chk("init_buf_level", 64'(buf_level), 64'd0);

    // single word from chip 0
    do_reset();
    chip_q[0].push_back(32'hA5A50001);
    n = 0;
    while (hptdc_get_data == '0 && n < 20) begin @(negedge clk); n++; end
    chk("t1_strobe", 64'(hptdc_get_data), 64'b0001);
    @(negedge clk); chk("t1_strobe_len", 64'(hptdc_get_data), 64'd0);
    @(negedge clk); chk("t1_ready", 64'(dn.data_ready), 64'd1);
    chk("t1_word", 64'(dn.data_out), 64'hA5A50001);
    @(negedge clk); chk("t1_level", 64'(buf_level), 64'd0);
    drain();

    // all chips requesting: strict rotation, one strobe every 3 cycles
    do_reset();
    for (int i = 0; i < N; i++) for (int k = 0; k < 3; k++) chip_q[i].push_back($urandom);
    for (int k = 0; k < 8; k++) begin got[k] = -1; at[k] = 0; end
    n = 0; cnt = 0;
    while (cnt < 8 && n < 60) begin
      @(negedge clk); n++;
      if (hptdc_get_data != '0) begin got[cnt] = oh2i(hptdc_get_data); at[cnt] = n; cnt++; end
    end
    for (int k = 0; k < 8; k++) chk("t2_order", 64'(got[k]), 64'(k % 4));
    for (int k = 1; k < 8; k++) chk("t2_spacing", 64'(at[k] - at[k-1]), 64'd3);
    drain();

    // downstream full: fill exactly D words, then stream them out in order
    do_reset();
    at_edge(); dn.full = 1'b1;
    for (int k = 0; k < 4; k++) for (int i = 0; i < N; i++) chip_q[i].push_back(t3w(i, k));
    cnt = 0;
    repeat (45) begin @(negedge clk); if (hptdc_get_data != '0) cnt++; end
    chk("t3_strobes", 64'(cnt), 64'd8);
    chk("t3_level", 64'(buf_level), 64'd8);
    chk("t3_no_strobe", 64'(hptdc_get_data), 64'd0);
    at_edge(); dn.full = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t3_ready", 64'(dn.data_ready), 64'd1);
      chk("t3_word", 64'(dn.data_out), 64'(tagw(k % 4, t3w(k % 4, k / 4))));
    end
    drain();

    // reset during a strobe with three words buffered
    do_reset();
    at_edge(); dn.full = 1'b1;
    for (int i = 0; i < N; i++) for (int k = 0; k < 2; k++) chip_q[i].push_back($urandom);
    n = 0; cnt = 0;
    while (cnt < 4 && n < 40) begin at_edge(); n++; if (hptdc_get_data != '0) cnt++; end
    chk("t4_level3", 64'(buf_level), 64'd3);
    reset = 1'b1;
    at_edge(); reset = 1'b0;
    @(negedge clk);
    chk("t4_get_data", 64'(hptdc_get_data), 64'd0);
    chk("t4_data_ready", 64'(dn.data_ready), 64'd0);
    chk("t4_data_out", 64'(dn.data_out), 64'd0);
    chk("t4_level", 64'(buf_level), 64'd0);
    at_edge(); dn.full = 1'b0;
    n = 0;
    while (hptdc_get_data == '0 && n < 20) begin @(negedge clk); n++; end
    chk("t4_ptr_restart", 64'(hptdc_get_data), 64'b0001);
    drain();

    // sticky error flag
    at_edge(); hptdc_error = 4'b0100;
    at_edge(); hptdc_error = '0;
    repeat (4) at_edge();
    @(negedge clk); chk("t5_err", 64'(error_flags), 64'b0100);
    do_reset();

    // chip 3 word, tagged when enabled
    chip_q[3].push_back(32'h12345678);
    n = 0;
    while (!dn.data_ready && n < 20) begin @(negedge clk); n++; end
`ifdef TAG_CHIP_ID_EN
    chk("t6_word", 64'(dn.data_out), 64'h3_1234_5678);
`else
    chk("t6_word", 64'(dn.data_out), 64'h1234_5678);
`endif
    drain();

    // randomized traffic, back-pressure, ready drops, errors and rare resets
    repeat (3000) begin
      at_edge();
      dn.full = ($urandom_range(0, 9) < 3);
      for (int i = 0; i < N; i++) rdy_mask[i] = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(0, N-1);
        if (chip_q[n].size() < 6) chip_q[n].push_back($urandom);
      end
      hptdc_error = ($urandom_range(0, 149) == 0) ? N'(1) << $urandom_range(0, N-1) : '0;
      reset = ($urandom_range(0, 599) == 0);
    end
    at_edge();
    reset = 1'b0; dn.full = 1'b0; rdy_mask = '1; hptdc_error = '0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hptdc_parallel_readout.md
Name: hptdc_parallel_readout

Overview:
- Multi-chip successor to the single-HPTDC parallel-port reader.
- Services N_CHIPS HPTDC parallel readout buses with a round-robin arbiter and strobes get_data one chip at a time.
- Buffers captured words in an internal FIFO and presents them to the downstream event FIFO with a valid/full write handshake.
- Sits between the HPTDC pins and the USB-side event FIFO; no word is ever lost or duplicated.

Parameters:
- DATA_W, 32, width of one HPTDC parallel data word.
- N_CHIPS, 4, number of HPTDC chips serviced (1..16).
- BUF_DEPTH, 8, internal buffer depth in words; power of two, at least 2.
- ID_W, 4, chip index width; must satisfy 2**ID_W >= N_CHIPS.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- hptdc_data  in  N_CHIPS*DATA_W  flattened per-chip data buses; chip i occupies [i*DATA_W +: DATA_W].
- hptdc_data_ready  in  N_CHIPS  per-chip "word available" flag.
- hptdc_get_data  out  N_CHIPS  per-chip read strobe; one-hot or zero.
- hptdc_error  in  N_CHIPS  per-chip error pin.
- data_out  out  DATA_W (+ID_W with TAG_CHIP_ID_EN)  word offered to the downstream FIFO.
- data_ready  out  1  data_out is valid.
- full  in  1  downstream FIFO is full.
- error_flags  out  N_CHIPS  sticky error latch, one bit per chip.
- buf_level  out  $clog2(BUF_DEPTH)+1  current internal buffer occupancy.

Behaviour:
- Reset values: hptdc_get_data=0, data_ready=0, data_out=0, error_flags=0, buf_level=0; buffer emptied; arbiter pointer=0; FSM=IDLE.
- Reset asserted mid-operation aborts any strobe in the next cycle and discards all buffered words.
- FSM states: IDLE, STROBE, GAP.
- IDLE: if any hptdc_data_ready bit is set and a buffer slot is free, select the first requesting chip at or after the pointer (modulo N_CHIPS), then go to STROBE.
- Slot-free condition: buf_level < BUF_DEPTH, counting the current-cycle pop.
- STROBE (1 cycle): hptdc_get_data[sel]=1. At the end of this cycle, latch hptdc_data[sel] into the buffer, set pointer=sel+1 (wrapping to 0 after N_CHIPS-1), and go to GAP.
- STROBE with hptdc_data_ready[sel] dropped: no push occurs; the pointer still advances.
- GAP (1 cycle): hptdc_get_data=0; gives the chip time to update data_ready. Then go to IDLE.
- Peak intake: one word per 3 cycles aggregate. Round-robin guarantees each requesting chip is serviced within N_CHIPS grants.
- Output handshake:
  - data_ready = buffer non-empty; data_out = head word (registered, FWFT).
  - A transfer occurs in any cycle with data_ready=1 and full=0; the head pops and the next word appears the following cycle.
  - data_out is held stable while full=1.
- Simultaneous push and pop: buf_level is unchanged.
- Buffer full: no new STROBE is issued. Words stay in the HPTDC's own readout FIFO, so nothing is dropped.
- Latency: first word reaches data_out 2 cycles after the STROBE cycle.
- error_flags[i] sets on any cycle with hptdc_error[i]=1 and clears only on reset.

Optional Feature:
- TAG_CHIP_ID_EN defined: data_out is DATA_W+ID_W wide, with {sel[ID_W-1:0], word}; the chip index is stored alongside each buffered word.
- Undefined: data_out is DATA_W wide, carrying the raw word; buffer width is DATA_W.

Decomposition:
- Package hptdc_readout_pkg holds:
  - FSM state enum (IDLE/STROBE/GAP);
  - default width constants;
  - the round-robin next-index function.
- Sub-module hptdc_word_fifo: synchronous FWFT FIFO, parameters WIDTH and DEPTH, ports push/pop/level/empty/full. It is instantiated once.

Test Plan:
- Single chip 0 presents 0xA5A50001 then drops ready; full=0 -> get_data[0] high exactly 1 cycle; data_out=0xA5A50001 with data_ready 2 cycles later; buf_level returns to 0.
- Chips 0..3 all hold ready continuously -> grants follow the order 0,1,2,3,0,... with one STROBE every 3 cycles; no chip is skipped.
- Hold full=1 with N_CHIPS=4, BUF_DEPTH=8 -> exactly 8 strobes, then buf_level=8 and no further get_data. Release full -> 8 words in arrival order, one per cycle, with no loss or duplication.
- Pulse reset for 1 cycle during STROBE with 3 words buffered -> next cycle all outputs are 0, buf_level=0, and the pointer restarts at chip 0.
- Pulse hptdc_error[2] for 1 cycle -> error_flags=4'b0100, persisting until reset.
- With TAG_CHIP_ID_EN, chip 3 word 0x12345678 -> data_out=0x3_12345678.
